// File: rtl/avmm_split_pkg.sv
// rtl/avmm_split_pkg.sv - shared types, widths and burst normalisation for the burst splitter
package avmm_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DRAIN,
    ST_WR_BEAT
  } state_t;

  localparam int AVMM_MAX_UPSTREAM_BURST = 64;
  localparam int AVMM_DATA_WIDTH         = 512;
  localparam int AVMM_BE_WIDTH           = 64;

  // A zero burstcount means a single word; anything beyond the upstream limit is clamped.
  function automatic logic [6:0] norm_burstcount(input logic [6:0] bc);
    if (bc == 7'd0) begin
      return 7'd1;
    end
    if (bc > 7'(AVMM_MAX_UPSTREAM_BURST)) begin
      return 7'(AVMM_MAX_UPSTREAM_BURST);
    end
    return bc;
  endfunction

endpackage

// File: rtl/avmm_burst_chunk_calc.sv
// rtl/avmm_burst_chunk_calc.sv - length of the next sub-burst that stays inside one MAX_BURST window
module avmm_burst_chunk_calc #(
  parameter int ADDR_WIDTH = 26,
  parameter int MAX_BURST  = 8
) (
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [6:0]            remaining,
  output logic [6:0]            chunk
);

  // MAX_BURST is a power of two, so the offset inside its window is a simple mask.
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(MAX_BURST - 1);

  logic [6:0] offset;
  logic [6:0] room;

  assign offset = 7'(address & OFFSET_MASK);
  assign room   = 7'(MAX_BURST) - offset;

  // Take whatever is left, but never run past the end of the aligned window.
  always_comb begin
    chunk = room;
    if (remaining < room) begin
      chunk = remaining;
    end
  end

endmodule

// File: rtl/avmm_burst_splitter.sv
// rtl/avmm_burst_splitter.sv - splits upstream Avalon-MM bursts into aligned downstream sub-bursts
module avmm_burst_splitter
  import avmm_split_pkg::*;
#(
  parameter int AVMM_ADDR_WIDTH = 26,
  parameter int MAX_BURST       = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       s_waitrequest,
  input  logic                       s_read,
  input  logic                       s_write,
  input  logic [AVMM_ADDR_WIDTH-1:0] s_address,
  input  logic [6:0]                 s_burstcount,
  input  logic [AVMM_DATA_WIDTH-1:0] s_writedata,
  input  logic [AVMM_BE_WIDTH-1:0]   s_byteenable,
  output logic [AVMM_DATA_WIDTH-1:0] s_readdata,
  output logic                       s_readdatavalid,
  input  logic                       m_waitrequest,
  output logic                       m_read,
  output logic                       m_write,
  output logic [AVMM_ADDR_WIDTH-1:0] m_address,
  output logic [6:0]                 m_burstcount,
  output logic [AVMM_DATA_WIDTH-1:0] m_writedata,
  output logic [AVMM_BE_WIDTH-1:0]   m_byteenable,
  input  logic [AVMM_DATA_WIDTH-1:0] m_readdata,
  input  logic                       m_readdatavalid
);

  state_t                     state;
  logic [6:0]                 remaining;
  logic [6:0]                 chunk_left;
  logic [6:0]                 outstanding;
  logic [6:0]                 out_next;
  logic [AVMM_ADDR_WIDTH-1:0] next_addr;
  logic [AVMM_ADDR_WIDTH-1:0] calc_addr;
  logic [6:0]                 calc_rem;
  logic [6:0]                 calc_chunk;
  logic                       rd_accept;
  logic                       wr_beat;

  assign next_addr   = m_address + AVMM_ADDR_WIDTH'(m_burstcount);
  assign rd_accept   = (state == ST_RD_ISSUE) && !m_waitrequest;
  assign wr_beat     = (state == ST_WR_BEAT) && s_write && !m_waitrequest;
  assign m_writedata = s_writedata;

  // Feed the chunk calculator with the address/remaining pair that the next register update needs.
  always_comb begin
    calc_addr = next_addr;
    calc_rem  = remaining - m_burstcount;
    case (state)
      ST_IDLE: begin
        calc_addr = s_address;
        calc_rem  = norm_burstcount(s_burstcount);
      end
      ST_WR_BEAT: calc_rem = remaining - 7'd1;
      default: ;
    endcase
  end

  avmm_burst_chunk_calc #(
    .ADDR_WIDTH(AVMM_ADDR_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_chunk_calc (
    .address  (calc_addr),
    .remaining(calc_rem),
    .chunk    (calc_chunk)
  );

  // Outstanding beats: add the accepted sub-burst and retire a returning beat together, floor at zero.
  always_comb begin
    out_next = outstanding + (rd_accept ? m_burstcount : 7'd0);
    if (m_readdatavalid && (out_next != 7'd0)) begin
      out_next = out_next - 7'd1;
    end
  end

  // Upstream stall and the write pass-through path; stalled and quiet while in reset.
  always_comb begin
    s_waitrequest = 1'b1;
    m_write       = 1'b0;
    m_byteenable  = '0;
    if (reset_n) begin
      case (state)
        ST_IDLE: s_waitrequest = !s_read;
        ST_WR_BEAT: begin
          s_waitrequest = m_waitrequest;
          m_write       = s_write;
          m_byteenable  = s_byteenable;
        end
        default: ;
      endcase
    end
  end

  // Command sequencing: reads issue sub-bursts back to back, writes step chunk by chunk per beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      m_read       <= 1'b0;
      m_address    <= '0;
      m_burstcount <= '0;
      remaining    <= '0;
      chunk_left   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_read) begin
            m_address    <= s_address;
            m_burstcount <= calc_chunk;
            remaining    <= calc_rem;
            m_read       <= 1'b1;
            state        <= ST_RD_ISSUE;
          end else if (s_write) begin
            m_address    <= s_address;
            m_burstcount <= calc_chunk;
            chunk_left   <= calc_chunk;
            remaining    <= calc_rem;
            state        <= ST_WR_BEAT;
          end
        end
        ST_RD_ISSUE: begin
          if (!m_waitrequest) begin
            remaining <= calc_rem;
            m_address <= next_addr;
            if (calc_rem == 7'd0) begin
              m_read <= 1'b0;
              state  <= ST_RD_DRAIN;
            end else begin
              m_burstcount <= calc_chunk;
            end
          end
        end
        ST_RD_DRAIN: begin
          if ((outstanding == 7'd0) && !m_readdatavalid) begin
            state <= ST_IDLE;
          end
        end
        ST_WR_BEAT: begin
          if (wr_beat) begin
            remaining  <= calc_rem;
            chunk_left <= chunk_left - 7'd1;
            if (chunk_left == 7'd1) begin
              m_address <= next_addr;
              if (calc_rem == 7'd0) begin
                state <= ST_IDLE;
              end else begin
                m_burstcount <= calc_chunk;
                chunk_left   <= calc_chunk;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read return stage and the outstanding-beat counter; reset drops anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata      <= '0;
      s_readdatavalid <= 1'b0;
      outstanding     <= '0;
    end else begin
      s_readdata      <= m_readdata;
      s_readdatavalid <= m_readdatavalid;
      outstanding     <= out_next;
    end
  end

endmodule

// File: tb/tb_avmm_burst_splitter.sv
// tb/tb_avmm_burst_splitter.sv - scoreboard bench with a downstream memory model and reference memory
module tb_avmm_burst_splitter;

  localparam int AW   = 26;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_waitrequest;
  logic          s_read, s_write;
  logic [AW-1:0] s_address;
  logic [6:0]    s_burstcount;
  logic [511:0]  s_writedata;
  logic [63:0]   s_byteenable;
  logic [511:0]  s_readdata;
  logic          s_readdatavalid;
  logic          m_waitrequest;
  logic          m_read, m_write;
  logic [AW-1:0] m_address;
  logic [6:0]    m_burstcount;
  logic [511:0]  m_writedata;
  logic [63:0]   m_byteenable;
  logic [511:0]  m_readdata;
  logic          m_readdatavalid;

  always #5 clk = ~clk;

  avmm_burst_splitter #(.AVMM_ADDR_WIDTH(AW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset_n(reset_n), .s_waitrequest(s_waitrequest),
    .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_burstcount(s_burstcount),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .m_waitrequest(m_waitrequest), .m_read(m_read),
    .m_write(m_write), .m_address(m_address), .m_burstcount(m_burstcount),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid)
  );

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [6:0]    cnt;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            cnt;
  } rdb_t;

  int            checks = 0;
  int            failures = 0;
  cmd_t          exp_cmd[$];
  logic [511:0]  exp_rd[$];
  rdb_t          rdq[$];
  logic [511:0]  mem[logic [AW-1:0]];
  logic [511:0]  ref_mem[logic [AW-1:0]];
  logic [511:0]  wdat[64];
  logic [63:0]   wbe[64];
  int            wr_left = 0;
  logic [AW-1:0] wr_addr = '0;
  int            beats_written = 0;
  int            rd_budget = -1;
  int            forced_stall = 0;
  bit            wait_rand = 1'b0;

  function automatic logic [511:0] pattern(input logic [AW-1:0] a);
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(k) << 26) ^ 32'h5A5A0000;
    return w;
  endfunction

  function automatic logic [511:0] merge(input logic [511:0] old, input logic [511:0] nw, input logic [63:0] be);
    logic [511:0] r;
    r = old;
    for (int b = 0; b < 64; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [511:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : pattern(a);
  endfunction

  function automatic logic [511:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  function automatic int norm(input int bc);
    return (bc == 0) ? 1 : ((bc > 64) ? 64 : bc);
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference split: walk the burst, cutting at every MAXB-aligned boundary, wrapping the address.
  task automatic push_cmds(input bit wr, input logic [AW-1:0] addr, input int n);
    logic [AW-1:0] a;
    int rem;
    int c;
    a = addr;
    rem = n;
    while (rem > 0) begin
      c = MAXB - int'(a % MAXB);
      if (c > rem) c = rem;
      exp_cmd.push_back({wr, a, 7'(c)});
      a = a + AW'(c);
      rem -= c;
    end
  endtask

  task automatic take_cmd(input cmd_t c);
    if (exp_cmd.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL cmd_unexpected actual=%0h required=none", c);
    end else begin
      chk("cmd", 512'(c), 512'(exp_cmd.pop_front()));
    end
  endtask

  // Downstream memory model: observe handshakes completing at the next rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      wr_left = 0;
    end else begin
      if (m_read && !m_waitrequest) begin
        take_cmd({1'b0, m_address, m_burstcount});
        rdq.push_back('{m_address, int'(m_burstcount)});
      end
      if (m_write && !m_waitrequest) begin
        if (wr_left == 0) begin
          take_cmd({1'b1, m_address, m_burstcount});
          wr_addr = m_address;
          wr_left = int'(m_burstcount);
        end
        mem[wr_addr] = merge(mem_rd(wr_addr), m_writedata, m_byteenable);
        wr_addr = wr_addr + 1'b1;
        if (wr_left > 0) wr_left--;
        beats_written++;
      end
    end
  end

  // Downstream drive: wait states and in-order read return with random gaps.
  always begin
    @(posedge clk);
    #2;
    if (forced_stall > 0) begin
      m_waitrequest = 1'b1;
      forced_stall--;
    end else begin
      m_waitrequest = wait_rand && ($urandom_range(0, 3) == 0);
    end
    if (!reset_n) begin
      rdq.delete();
      m_readdatavalid = 1'b0;
    end else if (rdq.size() > 0 && rd_budget != 0 && $urandom_range(0, 3) != 0) begin
      m_readdata = mem_rd(rdq[0].addr);
      m_readdatavalid = 1'b1;
      rdq[0].addr = rdq[0].addr + 1'b1;
      rdq[0].cnt--;
      if (rdq[0].cnt <= 0) void'(rdq.pop_front());
      if (rd_budget > 0) rd_budget--;
    end else begin
      m_readdatavalid = 1'b0;
      for (int k = 0; k < 16; k++) m_readdata[k*32 +: 32] = $urandom();
    end
  end

  // Upstream read monitor: every returned beat must be the next expected word.
  always @(negedge clk) begin
    if (reset_n && s_readdatavalid) begin
      if (exp_rd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_stray actual=%0h required=none", s_readdata);
      end else begin
        chk("rdata", s_readdata, exp_rd.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk_int({tag, "_rdv"}, int'(s_readdatavalid), 0);
    chk({tag, "_rdata"}, s_readdata, '0);
    chk_int({tag, "_mread"}, int'(m_read), 0);
    chk_int({tag, "_mwrite"}, int'(m_write), 0);
    chk_int({tag, "_maddr"}, int'(m_address), 0);
    chk_int({tag, "_mbc"}, int'(m_burstcount), 0);
    chk({tag, "_mbe"}, 512'(m_byteenable), '0);
    chk_int({tag, "_swait"}, int'(s_waitrequest), 1);
    chk_int({tag, "_state"}, int'(dut.state), int'(avmm_split_pkg::ST_IDLE));
  endtask

  task automatic issue_read(input logic [AW-1:0] addr, input int bc, input bit with_write);
    int n;
    int guard;
    bit acc;
    n = norm(bc);
    guard = 0;
    acc = 1'b0;
    push_cmds(1'b0, addr, n);
    for (int i = 0; i < n; i++) exp_rd.push_back(ref_rd(addr + AW'(i)));
    @(posedge clk);
    #1;
    s_read = 1'b1;
    s_write = with_write;
    s_address = addr;
    s_burstcount = 7'(bc);
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = !s_waitrequest;
      @(posedge clk);
      #1;
      guard++;
    end
    s_read = 1'b0;
    s_write = 1'b0;
    chk_int("rd_accepted", int'(acc), 1);
  endtask

  task automatic wait_rd_left(input int target, input string name);
    int guard;
    guard = 0;
    while (exp_rd.size() > target && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    chk_int(name, exp_rd.size(), target);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int bc, input bit with_write);
    issue_read(addr, bc, with_write);
    wait_rd_left(0, "rd_done");
    repeat (3) @(posedge clk);
    chk_int("rd_cmd_left", exp_cmd.size(), 0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int bc, input int gap_at, input int stall_at,
                          input int be_beat, input logic [63:0] be_val, input bit rand_be);
    int n;
    int i;
    int guard;
    bit took;
    n = norm(bc);
    i = 0;
    guard = 0;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 16; j++) wdat[k][j*32 +: 32] = $urandom();
      wbe[k] = rand_be ? {$urandom(), $urandom()} : '1;
      if (k == be_beat) wbe[k] = be_val;
      ref_mem[addr + AW'(k)] = merge(ref_rd(addr + AW'(k)), wdat[k], wbe[k]);
    end
    push_cmds(1'b1, addr, n);
    beats_written = 0;
    @(posedge clk);
    #1;
    s_write = 1'b1;
    s_address = addr;
    s_burstcount = 7'(bc);
    s_writedata = wdat[0];
    s_byteenable = wbe[0];
    while (i < n && guard < 1000) begin
      @(negedge clk);
      took = s_write && !s_waitrequest;
      @(posedge clk);
      #1;
      guard++;
      if (took) begin
        i++;
        if (i == stall_at) forced_stall = 3;
        if (i < n) begin
          s_writedata = wdat[i];
          s_byteenable = wbe[i];
        end
        if (i == gap_at && i < n) begin
          s_write = 1'b0;
          repeat (2) @(posedge clk);
          #1;
          s_write = 1'b1;
        end
      end
    end
    s_write = 1'b0;
    repeat (3) @(posedge clk);
    chk_int("wr_accepted", i, n);
    chk_int("wr_beats", beats_written, n);
    for (int k = 0; k < n; k++) chk("wr_mem", mem_rd(addr + AW'(k)), ref_rd(addr + AW'(k)));
    chk_int("wr_cmd_left", exp_cmd.size(), 0);
  endtask

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    s_read = 1'b0;
    s_write = 1'b0;
    s_address = '0;
    s_burstcount = '0;
    s_writedata = '0;
    s_byteenable = '0;
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    reset_n = 1'b1;

    do_read(26'h3, 16, 1'b0);
    do_write(26'h6, 10, -1, -1, 4, 64'h00FF, 1'b0);
    do_read(26'h6, 10, 1'b0);
    do_write(26'h3FFFFFF, 1, -1, -1, -1, '1, 1'b0);
    do_read(26'h3FFFFFF, 1, 1'b0);
    do_write(26'h3FFFFFE, 4, -1, -1, -1, '1, 1'b0);
    do_read(26'h3FFFFFE, 4, 1'b0);
    wait_rand = 1'b1;
    do_write(26'h20, 10, 5, 3, -1, '1, 1'b0);
    do_read(26'h20, 10, 1'b0);
    do_write(26'h100, 0, -1, -1, -1, '1, 1'b0);
    do_read(26'h100, 0, 1'b0);
    do_read(26'h40, 100, 1'b1);

    for (int t = 0; t < 24; t++) begin
      logic [AW-1:0] a;
      int bc;
      a = ($urandom_range(0, 3) == 0) ? AW'(32'h3FFFFFF - $urandom_range(0, 20)) : AW'($urandom());
      bc = int'($urandom_range(0, 127));
      wait_rand = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1)
        do_write(a, bc, int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), -1, '1, 1'b1);
      else
        do_read(a, bc, 1'b0);
    end

    wait_rand = 1'b0;
    rd_budget = 3;
    issue_read(26'h200, 8, 1'b0);
    wait_rd_left(5, "pre_reset_left");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_drain");
    exp_rd.delete();
    exp_cmd.delete();
    @(posedge clk);
    #1;
    rd_budget = -1;
    reset_n = 1'b1;
    do_read(26'h204, 4, 1'b0);

    repeat (5) @(posedge clk);
    chk_int("final_rd_left", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
